// File: rtl/incrementer_arbiter.sv
// incrementer_arbiter
// Round-robin front end for a single shared (WIDTH)-bit incrementer. Each
// requester has its own valid/ready request channel. Results come back on one
// valid/ready response channel tagged with the owning requester's index.
// Only one transaction is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module incrementer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_overflow,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   rr_ptr_next;
    logic [WIDTH-1:0] op_reg;
    logic [IDW-1:0]   id_reg;
    logic             rsp_valid_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_overflow_reg;

    logic [WIDTH-1:0] op_arr [NUM_REQ];
    logic [IDW-1:0]   winner;
    logic             found;
    logic             grant_en;
    logic [WIDTH:0]   sum;

    // Unpack the flat operand bus into one entry per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting at rr_ptr. Scanning from the farthest offset
    // down to zero lets the nearest valid requester overwrite the result last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDW'((int'(rr_ptr_reg) + k) % NUM_REQ)]) begin
                winner = IDW'((int'(rr_ptr_reg) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // A grant is only offered in IDLE and never while reset is asserted, so a
    // requester can never see a handshake that the register stage then drops.
    assign grant_en = (state_reg == IDLE) && found && !rst;

    // One-hot ready toward the winning requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (winner == IDW'(gi));
        end
    endgenerate

    // Pointer advances to the requester after the winner, wrapping at NUM_REQ.
    assign rr_ptr_next = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

    // The shared incrementer, one bit wider so the carry becomes the overflow flag.
    assign sum = {1'b0, op_reg} + {{WIDTH{1'b0}}, 1'b1};

    // Next-state logic for the single-transaction sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_en)  state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State, arbitration pointer, captured request and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            op_reg           <= '0;
            id_reg           <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= '0;
            rsp_data_reg     <= '0;
            rsp_overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_en) begin
                op_reg     <= op_arr[winner];
                id_reg     <= winner;
                rr_ptr_reg <= rr_ptr_next;
            end
            if (state_reg == EXEC) begin
                {rsp_overflow_reg, rsp_data_reg} <= sum;
                rsp_id_reg                       <= id_reg;
                rsp_valid_reg                    <= 1'b1;
            end
            if ((state_reg == RESP) && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_incrementer_arbiter.sv
// Directed testbench for incrementer_arbiter (NUM_REQ=4, WIDTH=4).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_incrementer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_overflow;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_grant_cyc;
    int grant_cyc;

    incrementer_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_overflow(rsp_overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [WIDTH-1:0] v);
        req_data[idx*WIDTH +: WIDTH] = v;
    endtask

    // Called at a falling edge with the DUT in IDLE and requests applied.
    // Expects requester g to be granted and its result d/o two cycles later,
    // accepted immediately (rsp_ready must be 1). Returns at a falling edge
    // with the DUT back in IDLE.
    task automatic serve(input int g, input logic [WIDTH-1:0] d, input logic o, input logic drop);
        logic [NUM_REQ-1:0] onehot;
        onehot = '0;
        onehot[g] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(onehot));
        @(posedge clk);
        #1;
        grant_cyc = cyc;
        if (drop) req_valid[g] = 1'b0;
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_data", 32'(rsp_data), 32'(d));
        check("rsp_overflow", 32'(rsp_overflow), 32'(o));
        $display("txn: grant=%0d id=%0d data=%0d ovf=%0d at cycle %0d", g, rsp_id, rsp_data, rsp_overflow, grant_cyc);
        @(negedge clk);
        check("after_accept_valid", 32'(rsp_valid), 32'd0);
        check("after_accept_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset: ready must stay low even with a request present.
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_ovf", 32'(rsp_overflow), 32'd0);
        rst = 1'b0;

        // Basic: req0 a=7 -> 8
        req_valid = 4'b0001;
        set_op(0, 4'd7);
        serve(0, 4'd8, 1'b0, 1'b1);

        // Wrap-around and neighbours (rr_ptr=1)
        req_valid = 4'b0100; set_op(2, 4'd15);
        serve(2, 4'd0, 1'b1, 1'b1);
        req_valid = 4'b0010; set_op(1, 4'd14);
        serve(1, 4'd15, 1'b0, 1'b1);
        req_valid = 4'b1000; set_op(3, 4'd0);
        serve(3, 4'd1, 1'b0, 1'b1);

        // Pointer wrapped to 0: req0 beats req3, then req3 still pending
        req_valid = 4'b1001; set_op(0, 4'd5); set_op(3, 4'd9);
        serve(0, 4'd6, 1'b0, 1'b1);
        check("loser_pending", 32'(req_valid), 32'b1000);
        serve(3, 4'd10, 1'b0, 1'b1);

        // All valid continuously after reset: 0,1,2,3,0, three cycles apart
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        set_op(0, 4'd1); set_op(1, 4'd2); set_op(2, 4'd3); set_op(3, 4'd4);
        serve(0, 4'd2, 1'b0, 1'b0);
        last_grant_cyc = grant_cyc;
        for (int i = 1; i <= 4; i++) begin
            serve(i % 4, 4'((i % 4) + 2), 1'b0, 1'b0);
            check("grant_spacing", 32'(grant_cyc - last_grant_cyc), 32'd3);
            last_grant_cyc = grant_cyc;
        end

        // Backpressure: rr_ptr=1, req1 a=6 wins, req0 waits
        req_valid = 4'b0011; set_op(1, 4'd6);
        rsp_ready = 1'b0;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'd7);
            check("bp_rsp_ovf", 32'(rsp_overflow), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_still_valid", 32'(rsp_valid), 32'd1);
        $display("txn: grant=1 id=%0d data=%0d ovf=%0d accepted after backpressure", rsp_id, rsp_data, rsp_overflow);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b0001);
        serve(0, 4'd2, 1'b0, 1'b1);

        // Reset during EXEC: rr_ptr=1, req2 a=3 granted then discarded
        req_valid = 4'b0100; set_op(2, 4'd3);
        #1;
        check("rst_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("rst_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("discarded_no_rsp", 32'(rsp_valid), 32'd0);
        end
        // rr_ptr back at 0: req0 wins over req3 (req3 would win from ptr 3)
        req_valid = 4'b1001; set_op(0, 4'd11); set_op(3, 4'd2);
        serve(0, 4'd12, 1'b0, 1'b1);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
